shift_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the 16-bit shift/rotate unit. Accepts one shift request
//  per transaction over a valid/ready handshake and applies the log-stage network one

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_stage.sv | 35 +++
 rtl/shift_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op/state encodings and default sizes for the shift sequencer
package shift_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_SHAMT_W = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_ROR = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one stage of the log shifter: shifts d by 2^k when en is set
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int K_W   = 2
) (
    input  logic [WIDTH-1:0] d,
    input  logic [K_W-1:0]   k,
    input  op_e              op,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_ror;

    always_comb begin
        w_sll = d << (1 << k);
        w_sra = WIDTH'($signed(d) >>> (1 << k));
        // Rotate as the low half of the doubled word shifted right.
        w_ror = WIDTH'({d, d} >> (1 << k));
        q     = d;
        if (en) begin
            case (op)
                OP_SLL:  q = w_sll;
                OP_SRA:  q = w_sra;
                OP_ROR:  q = w_ror;
                default: q = d;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle shift/rotate sequencer; SHIFT_SEQ_SKIP_EN skips zero shamt bits
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_data,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [1:0]         req_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_err
);

    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_e             r_state;
    logic               r_ready;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    op_e                r_op;
    logic               r_err;

    logic [K_W-1:0]     w_k;
    logic               w_en;
    logic               w_last;
    logic               w_fast;
    logic [WIDTH-1:0]   w_q;

`ifdef SHIFT_SEQ_SKIP_EN
    // r_shamt doubles as the residual mask of stages still to apply.
    logic [SHAMT_W-1:0] w_mask_nxt;

    always_comb begin
        w_k = '0;
        for (int i = SHAMT_W - 1; i >= 0; i--) begin
            if (r_shamt[i]) w_k = K_W'(i);
        end
        w_en       = |r_shamt;
        w_mask_nxt = r_shamt & (r_shamt - SHAMT_W'(1));
        w_last     = (w_mask_nxt == '0);
        w_fast     = (req_shamt == '0);
    end
`else
    logic [K_W-1:0] r_cnt;

    always_comb begin
        w_k    = r_cnt;
        w_en   = r_shamt[r_cnt];
        w_last = (r_cnt == K_W'(SHAMT_W - 1));
        w_fast = 1'b0;
    end
`endif

    shift_stage #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_stage (
        .d  (r_data),
        .k  (w_k),
        .op (r_op),
        .en (w_en),
        .q  (w_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_op    <= OP_SLL;
            r_err   <= 1'b0;
`ifndef SHIFT_SEQ_SKIP_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_data  <= req_data;
                        r_shamt <= req_shamt;
                        r_op    <= op_e'(req_op);
                        r_err   <= (req_op == OP_ILL);
                        r_ready <= 1'b0;
`ifndef SHIFT_SEQ_SKIP_EN
                        r_cnt   <= '0;
`endif
                        // Illegal ops (and empty masks when skipping) finish at the accept edge.
                        if ((req_op == OP_ILL) || w_fast) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    r_data <= w_q;
`ifdef SHIFT_SEQ_SKIP_EN
                    r_shamt <= w_mask_nxt;
`else
                    r_cnt   <= r_cnt + K_W'(1);
`endif
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_valid;
    assign resp_data  = r_data;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl against a transaction-level model
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [3:0]  req_shamt = '0;
    logic [1:0]  req_op = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_err;

    shift_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: 0 idle, 1 working, 2 holding a response.
    int          m_st = 0;
    logic [15:0] m_exp = '0;
    logic        m_err = 1'b0;
    int          m_left = 0;
    int          m_acc_n = 0;
    int          m_acc_cyc = 0;
    bit          m_zero = 1'b1;
    bit          mon_en = 1'b0;

    function automatic logic [15:0] ref_shift(logic [1:0] op, logic [15:0] d, int s);
        case (op)
            2'd0:    return d << s;
            2'd1:    return 16'($signed(d) >>> s);
            2'd2:    return (d >> s) | (d << (16 - s));
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(logic [1:0] op, logic [3:0] s);
        if (op == 2'd3) return 0;
`ifdef SHIFT_SEQ_SKIP_EN
        return $countones(s);
`else
        return 4;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_st   = 0;
            m_zero = 1'b1;
        end else begin
            case (m_st)
                0: if (req_valid) begin
                    m_exp     = ref_shift(req_op, req_data, int'(req_shamt));
                    m_err     = (req_op == 2'd3);
                    m_left    = ref_lat(req_op, req_shamt);
                    m_acc_cyc = cyc;
                    m_acc_n++;
                    m_zero    = 1'b0;
                    m_st      = (m_left == 0) ? 2 : 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_st = 2;
                end
                default: if (resp_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_req_ready", req_ready, m_st == 0);
            chk("mon_resp_valid", resp_valid, m_st == 2);
            if (m_st == 2) begin
                chk("mon_resp_data", resp_data, m_exp);
                chk("mon_resp_err", resp_err, m_err);
            end
            if (m_zero) begin
                chk("mon_zero_data", resp_data, 0);
                chk("mon_zero_err", resp_err, 0);
            end
        end
    end

    task automatic send(logic [1:0] op, logic [15:0] d, logic [3:0] s);
        int n0;
        n0        = m_acc_n;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        req_shamt = s;
        for (int i = 0; i < 60 && m_acc_n == n0; i++) @(negedge clk);
        if (m_acc_n == n0) chk("accept_timeout", 0, 1);
        req_valid = 1'b0;
        req_data  = 16'($urandom);
        req_shamt = 4'($urandom);
        req_op    = 2'($urandom);
    endtask

    task automatic recv(int hold, output int lat, output logic [15:0] d, output logic e);
        for (int i = 0; i < 60 && !resp_valid; i++) @(negedge clk);
        if (!resp_valid) chk("resp_timeout", 0, 1);
        lat = cyc - m_acc_cyc;
        d   = resp_data;
        e   = resp_err;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic directed(string name, logic [1:0] op, logic [15:0] d, logic [3:0] s,
                            logic [15:0] exp_d, logic exp_e, int exp_lat);
        int          lat;
        logic [15:0] rd;
        logic        re;
        send(op, d, s);
        recv(1, lat, rd, re);
        chk({name, "_data"}, rd, exp_d);
        chk({name, "_err"}, re, exp_e);
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        re;
        logic [1:0]  op;
        logic [15:0] d;
        logic [3:0]  s;

        chk("model_ror", ref_shift(2'd2, 16'h1234, 4), 16'h4123);
        chk("model_sra", ref_shift(2'd1, 16'h8000, 15), 16'hFFFF);
        chk("model_sll", ref_shift(2'd0, 16'h0001, 15), 16'h8000);
        chk("model_ror0", ref_shift(2'd2, 16'hBEEF, 0), 16'hBEEF);

        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_err", resp_err, 0);

`ifdef SHIFT_SEQ_SKIP_EN
        directed("ror_1234", 2'd2, 16'h1234, 4'd4, 16'h4123, 1'b0, 1);
        directed("sll_ffff_s0", 2'd0, 16'hFFFF, 4'd0, 16'hFFFF, 1'b0, 0);
        directed("skip_ror_00f0", 2'd2, 16'h00F0, 4'd8, 16'hF000, 1'b0, 1);
`else
        directed("ror_1234", 2'd2, 16'h1234, 4'd4, 16'h4123, 1'b0, 4);
        directed("sll_ffff_s0", 2'd0, 16'hFFFF, 4'd0, 16'hFFFF, 1'b0, 4);
`endif
        directed("sra_8000", 2'd1, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 4);
        directed("sll_0001", 2'd0, 16'h0001, 4'd15, 16'h8000, 1'b0, 4);
        directed("illegal", 2'd3, 16'hA5A5, 4'd7, 16'hA5A5, 1'b1, 0);

        // Backpressure with a competing request waiting.
        send(2'd0, 16'h0003, 4'd1);
        for (int i = 0; i < 60 && !resp_valid; i++) @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = 16'h8421;
        req_shamt = 4'd2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_data", resp_data, 16'h0006);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_hs_req_ready", req_ready, 1);
        @(negedge clk);
        chk("bp_acc_req_ready", req_ready, 0);
        req_valid = 1'b0;
        recv(0, lat, rd, re);
        chk("bp_second_data", rd, 16'hE108);
`ifdef SHIFT_SEQ_SKIP_EN
        chk("bp_second_lat", lat, 1);
`else
        chk("bp_second_lat", lat, 4);
`endif

        // Reset while two stages in.
        send(2'd0, 16'h1111, 4'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_data", resp_data, 0);
`ifdef SHIFT_SEQ_SKIP_EN
        directed("after_rst", 2'd2, 16'h1234, 4'd4, 16'h4123, 1'b0, 1);
`else
        directed("after_rst", 2'd2, 16'h1234, 4'd4, 16'h4123, 1'b0, 4);
`endif

        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = 2'($urandom_range(0, 3));
            d  = 16'($urandom);
            s  = 4'($urandom);
            send(op, d, s);
            recv($urandom_range(0, 3), lat, rd, re);
            chk("rnd_data", rd, ref_shift(op, d, int'(s)));
            chk("rnd_err", re, op == 2'd3);
            chk("rnd_lat", lat, ref_lat(op, s));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
